reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Reset generator: the producer side of the reset input that every flip-flop in the design consumes. It accepts an asynchronous reset request (pin or button), a synchronous software request, and a clock-good indication. It drives NUM_STAGES active-high resets with asynchronous assertion and synchronous, staggered release. It sits at the top level, between the board inputs and all downstream reset pins.

Parameters:
SYNC_STAGES, 2, synchronizer depth for async_req deassertion (min 2)
HOLD_CYCLES, 16, cycles all resets stay asserted after the request clears and clk_ok is high (min 1)
NUM_STAGES, 3, number of staggered reset outputs (min 1)
STAGE_GAP, 4, cycles between successive output releases (min 1)
CNT_W, 8, width of hold/gap counter; must hold max(HOLD_CYCLES, STAGE_GAP)

Ports:
clock  in  1  system clock
reset  in  1  master reset: synchronous, active-high
async_req  in  1  asynchronous reset request, active-high, may change at any time
sw_req  in  1  synchronous one-cycle reset request, active-high
clk_ok  in  1  clock/PLL good; releases are blocked while low
rst_out  out  NUM_STAGES  active-high resets; bit 0 is released first
busy  out  1  high whenever any rst_out bit is high
done  out  1  one-cycle pulse on the cycle the FSM enters RUN
req_count  out  8  saturating count of accepted reset requests

Behaviour:
- Reset values:
  - On master reset, the synchronizer flops are 1, state = ASSERT, and rst_out = all ones.
  - busy = 1, done = 0, req_count = 0, counter = 0.
- Asynchronous assertion:
  - async_req high asynchronously sets all synchronizer flops and all rst_out bits.
  - This is the only asynchronous path. The flops it sets also carry synchronous master-reset logic.
- Synchronous deassertion:
  - req_sync is the last synchronizer flop. A 0 shifts in once per clock.
  - req_sync goes low SYNC_STAGES edges after async_req falls.
- FSM states: ASSERT, HOLD, RELEASE, RUN.
  - Trigger = req_sync OR sw_req OR NOT clk_ok.
  - ASSERT: rst_out all ones. Go to HOLD when trigger is low; counter cleared.
  - HOLD: counter increments each cycle. Trigger high -> back to ASSERT, counter cleared. When counter = HOLD_CYCLES-1 and trigger is low: go to RELEASE, clear rst_out[0] on that edge, counter cleared, stage index = 1.
  - RELEASE: counter increments each cycle. When counter = STAGE_GAP-1: clear rst_out[stage index], increment stage index, clear counter. The edge that clears rst_out[NUM_STAGES-1] moves to RUN.
  - NUM_STAGES = 1: HOLD goes directly to RUN.
  - RUN: rst_out all zeros.
  - Trigger high in RELEASE or RUN -> ASSERT. All rst_out bits are set on that same edge.
- Release timing: with HOLD entered at edge N, rst_out[k] clears at edge N + HOLD_CYCLES + k*STAGE_GAP.
- done is high for exactly the one cycle following entry into RUN.
- busy = OR of rst_out.
- req_count increments once per rising edge of the trigger observed in RELEASE or RUN, and saturates at 255.
- Simultaneous events:
  - Master reset has priority over everything except the async set, which also asserts outputs.
  - sw_req on the same edge as the final release wins: go to ASSERT, bit stays/returns high, no done.
- Master reset mid-sequence: returns to the reset values; sequencing restarts from ASSERT.
- Outputs never glitch low: every release goes through a registered clear.

Decomposition:
- Shared package rst_seq_pkg: state encoding constants (ASSERT=0, HOLD=1, RELEASE=2, RUN=3), counter width helper, REQ_COUNT_MAX=255.
- One sub-module: reset_sync_chain (SYNC_STAGES flops, async set on async_req, synchronous set on reset), producing req_sync.
- The FSM, counters and rst_out register stay in reset_sequencer.

Test Plan:
- Power-up: reset high 3 cycles, then low, async_req=0, clk_ok=1.
  - req_sync clears at edge 2 and HOLD is entered at edge 3.
  - rst_out bits clear at edges 19/23/27; done pulses in the cycle after edge 27; busy falls at edge 27.
- Async pulse in RUN: async_req high mid-cycle for 3 ns.
  - rst_out = 111 immediately, before the next edge; req_count = 1.
  - Full release sequence repeats, with bit 0 clearing 2+16 edges after the next edge.
- Retrigger during HOLD: sw_req pulse at HOLD counter = 10 -> back to ASSERT; bit 0 clears 1+16 edges after the sw_req edge; no output bit drops early.
- Retrigger during RELEASE: clk_ok low for 1 cycle after bit 0 is released -> rst_out = 111 on the next edge; req_count increments; full sequence restarts.
- Saturation: 300 sw_req pulses spaced in RUN -> req_count = 255 and stays there.
- Final-edge collision: sw_req on the edge that would clear rst_out[2] -> rst_out = 111, state ASSERT, done stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer slice.
// Holds the FSM state encoding, the request counter ceiling and a width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [7:0] REQ_COUNT_MAX = 8'd255;

  // Bits needed to hold values 0..value (never less than one bit).
  function automatic int width_for(input int value);
    return (value < 1) ? 1 : $clog2(value + 1);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Request synchronizer: set asynchronously by async_req, released one stage per clock.
// The last stage is the synchronized request seen by the sequencer FSM.
module reset_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_req,
  output logic req_sync
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clock or posedge async_req) begin
    if (async_req) begin
      sync_reg <= '1;
    end else if (reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign req_sync = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset generator: asynchronous assertion, synchronous staggered release of NUM_STAGES resets.
// Any request, or loss of clk_ok, forces every output back into reset.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  async_req,
  input  logic                  sw_req,
  input  logic                  clk_ok,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            req_count
);

  localparam int IDX_W = width_for(NUM_STAGES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        stage_reg, stage_next;
  logic [NUM_STAGES-1:0]   rst_out_reg, rst_out_next;
  logic                    done_reg;
  logic                    trig_prev_reg;
  logic [7:0]              req_count_reg;
  logic                    req_sync;
  logic                    trigger;
  logic                    count_hit;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_req(async_req),
    .req_sync (req_sync)
  );

  assign trigger   = req_sync | sw_req | ~clk_ok;
  assign count_hit = ((state_reg == RELEASE) || (state_reg == RUN)) && trigger && !trig_prev_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    stage_next   = stage_reg;
    rst_out_next = rst_out_reg;
    case (state_reg)
      ASSERT: begin
        rst_out_next = '1;
        cnt_next     = '0;
        if (!trigger) state_next = HOLD;
      end
      HOLD: begin
        if (trigger) begin
          state_next   = ASSERT;
          cnt_next     = '0;
          rst_out_next = '1;
        end else if (cnt_reg == HOLD_LAST) begin
          cnt_next        = '0;
          rst_out_next[0] = 1'b0;
          stage_next      = IDX_W'(1);
          state_next      = (NUM_STAGES == 1) ? RUN : RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        if (trigger) begin
          state_next   = ASSERT;
          cnt_next     = '0;
          rst_out_next = '1;
        end else if (cnt_reg == GAP_LAST) begin
          // Release exactly the stage the index points at; earlier stages are already low.
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_reg == IDX_W'(i)) rst_out_next[i] = 1'b0;
          end
          cnt_next   = '0;
          stage_next = stage_reg + IDX_W'(1);
          if (stage_reg == LAST_IDX) state_next = RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        rst_out_next = '0;
        if (trigger) begin
          state_next   = ASSERT;
          cnt_next     = '0;
          rst_out_next = '1;
        end
      end
      default: begin
        state_next   = ASSERT;
        cnt_next     = '0;
        rst_out_next = '1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ASSERT;
      cnt_reg       <= '0;
      stage_reg     <= '0;
      done_reg      <= 1'b0;
      trig_prev_reg <= 1'b1;
      req_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      stage_reg     <= stage_next;
      done_reg      <= (state_next == RUN) && (state_reg != RUN);
      trig_prev_reg <= trigger;
      if (count_hit && (req_count_reg != REQ_COUNT_MAX)) begin
        req_count_reg <= req_count_reg + 8'd1;
      end
    end
  end

  // Outputs are set asynchronously by the request pin, but only ever cleared by a clock edge.
  always_ff @(posedge clock or posedge async_req) begin
    if (async_req) begin
      rst_out_reg <= '1;
    end else if (reset) begin
      rst_out_reg <= '1;
    end else begin
      rst_out_reg <= rst_out_next;
    end
  end

  assign rst_out   = rst_out_reg;
  assign busy      = |rst_out_reg;
  assign done      = done_reg;
  assign req_count = req_count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a vector table for release timing and retriggers,
// plus hand-written async-pulse, saturation and master-reset sequences.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       async_req;
  logic       sw_req;
  logic       clk_ok;
  logic [2:0] rst_out;
  logic       busy;
  logic       done;
  logic [7:0] req_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(16),
    .NUM_STAGES (3),
    .STAGE_GAP  (4),
    .CNT_W      (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .async_req(async_req),
    .sw_req   (sw_req),
    .clk_ok   (clk_ok),
    .rst_out  (rst_out),
    .busy     (busy),
    .done     (done),
    .req_count(req_count)
  );

  typedef struct {
    int         cyc;
    logic       sw;
    logic       ok;
    logic [2:0] rst;
    logic       bsy;
    logic       dn;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int r, input int b, input int d, input int c);
    check({tag, "_rst"},  int'(rst_out),   r);
    check({tag, "_busy"}, int'(busy),      b);
    check({tag, "_done"}, int'(done),      d);
    check({tag, "_cnt"},  int'(req_count), c);
  endtask

  function automatic void add(input int c, input logic s, input logic o, input logic [2:0] r,
                              input logic b, input logic d, input int n);
    vec_t v;
    v.cyc = c; v.sw = s; v.ok = o; v.rst = r; v.bsy = b; v.dn = d; v.cnt = n;
    vecs.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt;
    int n;

    // Edge numbers below count from the first edge after reset is released.
    // Power-up: HOLD at edge 3, releases at 19/23/27.
    add(18, 0, 1, 3'b111, 1, 0, 0);
    add(1,  0, 1, 3'b110, 1, 0, 0);
    add(3,  0, 1, 3'b110, 1, 0, 0);
    add(1,  0, 1, 3'b100, 1, 0, 0);
    add(3,  0, 1, 3'b100, 1, 0, 0);
    add(1,  0, 1, 3'b000, 0, 1, 0);
    add(1,  0, 1, 3'b000, 0, 0, 0);
    // sw_req in RUN at edge 29, HOLD at 30, retrigger at counter 10 (edge 41), HOLD at 42.
    add(1,  1, 1, 3'b111, 1, 0, 1);
    add(11, 0, 1, 3'b111, 1, 0, 1);
    add(1,  1, 1, 3'b111, 1, 0, 1);
    add(16, 0, 1, 3'b111, 1, 0, 1);
    add(1,  0, 1, 3'b110, 1, 0, 1);
    // clk_ok low for one cycle in RELEASE (edge 59), HOLD at 60.
    add(1,  0, 0, 3'b111, 1, 0, 2);
    add(16, 0, 1, 3'b111, 1, 0, 2);
    add(1,  0, 1, 3'b110, 1, 0, 2);
    add(4,  0, 1, 3'b100, 1, 0, 2);
    add(3,  0, 1, 3'b100, 1, 0, 2);
    // sw_req on the final-release edge 84: back to reset, no done; HOLD at 85.
    add(1,  1, 1, 3'b111, 1, 0, 3);
    add(1,  0, 1, 3'b111, 1, 0, 3);
    add(15, 0, 1, 3'b111, 1, 0, 3);
    add(1,  0, 1, 3'b110, 1, 0, 3);
    add(8,  0, 1, 3'b000, 0, 1, 3);
    add(1,  0, 1, 3'b000, 0, 0, 3);

    reset     = 1'b1;
    async_req = 1'b0;
    sw_req    = 1'b0;
    clk_ok    = 1'b1;
    cycle(3);
    check_outs("reset", 7, 1, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      sw_req = vecs[i].sw;
      clk_ok = vecs[i].ok;
      cycle(vecs[i].cyc);
      check_outs($sformatf("row%0d", i), int'(vecs[i].rst), int'(vecs[i].bsy),
                 int'(vecs[i].dn), vecs[i].cnt);
    end
    sw_req = 1'b0;
    clk_ok = 1'b1;

    // Async pulse mid-cycle while in RUN: outputs rise before the next edge.
    #3 async_req = 1'b1;
    #1 check("async_immediate_rst", int'(rst_out), 7);
    check("async_immediate_busy", int'(busy), 1);
    #2 async_req = 1'b0;
    @(posedge clock);
    #2;
    check_outs("async_e0", 7, 1, 0, 4);
    cycle(17);
    check_outs("async_e17", 7, 1, 0, 4);
    cycle(1);
    check_outs("async_e18", 6, 1, 0, 4);
    cycle(8);
    check_outs("async_e26", 0, 0, 1, 4);

    // Saturation: one sw_req per completed sequence.
    exp_cnt = 4;
    for (int i = 0; i < 300; i++) begin
      sw_req = 1'b1;
      cycle(1);
      sw_req = 1'b0;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check($sformatf("sat_cnt%0d", i), int'(req_count), exp_cnt);
      n = 0;
      while (busy && n < 60) begin
        cycle(1);
        n++;
      end
      check($sformatf("sat_run%0d", i), int'(busy), 0);
    end

    // Master reset in the middle of RELEASE restarts from ASSERT.
    sw_req = 1'b1;
    cycle(1);
    sw_req = 1'b0;
    check("sat_hold", int'(req_count), 255);
    cycle(19);
    check("mid_release_rst", int'(rst_out), 6);
    reset = 1'b1;
    cycle(1);
    check_outs("mid_reset", 7, 1, 0, 0);
    reset = 1'b0;
    cycle(18);
    check_outs("restart_e18", 7, 1, 0, 0);
    cycle(1);
    check_outs("restart_e19", 6, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
